sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one sram-like memory port between the IF fetch requester (read-only) and the EX/MEM data requester.
//  Sits between the pipeline stages and the single external memory interface.
//  Holds at most one outstanding transaction: arbitrate, latch the request, issue it, wait for the response.
//  Data side has priority; a starvation counter guarantees fetch progress.
//  Exports busy for CTRL stall generation.
// PARAMETERS
//  ADDR_W           32  address width, all ports
//  DATA_W           32  data width; byte strobe width is DATA_W/8
//  DATA_STREAK_MAX  4   consecutive data grants allowed while inst_req is pending; must be >= 1
// PORTS
//  clk            in   1         clock, all state updates on rising edge
//  rst            in   1         synchronous reset, active-high
//  inst_req       in   1         fetch request; held until inst_addr_ok
//  inst_addr      in   ADDR_W    fetch address
//  inst_addr_ok   out  1         1-cycle pulse: fetch request granted and latched
//  inst_data_ok   out  1         1-cycle pulse: fetch data valid on inst_rdata
//  inst_rdata     out  DATA_W    fetch read data (valid only with inst_data_ok)
//  data_req       in   1         load/store request; held until data_addr_ok
//  data_wr        in   1         1 = store, 0 = load
//  data_wstrb     in   DATA_W/8  byte enables for stores
//  data_addr      in   ADDR_W    load/store address
//  data_wdata     in   DATA_W    store data
//  data_addr_ok   out  1         1-cycle pulse: data request granted and latched
//  data_data_ok   out  1         1-cycle pulse: load data valid, or store complete
//  data_rdata     out  DATA_W    load data (valid only with data_data_ok)
//  mem_req        out  1         request to memory; held until mem_addr_ok
//  mem_wr         out  1         latched write flag
//  mem_wstrb      out  DATA_W/8  latched strobes; 0 for reads
//  mem_addr       out  ADDR_W    latched address
//  mem_wdata      out  DATA_W    latched write data
//  mem_addr_ok    in   1         memory accepted mem_req this cycle
//  mem_data_ok    in   1         memory response valid this cycle
//  mem_rdata      in   DATA_W    memory read data
//  busy           out  1         FSM not in IDLE, or any request pending
// BEHAVIOUR
//  FSM states: IDLE, ISSUE, RESP. Reset (rst=1 at an edge) state: IDLE.
//  Reset values: all pulses 0, mem_req 0, latched fields 0, owner=INST, streak counter 0.
//  IDLE, no request pending: stay in IDLE.
//  IDLE, request pending:
//   - Grant data if data_req, unless inst_req && streak == DATA_STREAK_MAX; otherwise grant inst.
//   - Same cycle: granted side's *_addr_ok = 1 (combinational).
//   - Next edge: latch addr/wr/wstrb/wdata and owner; go to ISSUE.
//   - A fetch grant latches wr=0 and wstrb=0.
//  Streak counter, updated at each grant edge:
//   - Data grant while inst_req=1: counter +1, saturating at DATA_STREAK_MAX.
//   - Any inst grant, or a data grant with inst_req=0: counter cleared to 0.
//  ISSUE: mem_req=1 with latched fields. On mem_addr_ok=1, go to RESP at the next edge.
//  RESP: mem_req=0. On mem_data_ok=1:
//   - Owner's *_data_ok = 1 and *_rdata = mem_rdata, same cycle (combinational).
//   - Next edge: go to IDLE.
//  Latency: req sampled in cycle N; mem_req first high in N+1.
//   - Best case: addr_ok in N+1, data_ok in N+2, next grant in N+3.
//  mem_data_ok is ignored outside RESP. rdata outputs are 0 when the matching data_ok is 0.
//  Requests are not accepted outside IDLE; requesters simply keep req high.
//  Both requests in the same IDLE cycle: exactly one addr_ok pulse; the loser keeps waiting.
//  Store with wstrb=0: issued normally as a write and completes with data_data_ok.
//  rst in ISSUE or RESP: return to IDLE and drop mem_req next cycle. No data_ok is produced.
//   - The memory side is reset by the same rst.
//  Latched fields must not change between the grant and mem_addr_ok, even if requester inputs change.
// TESTING
//  1. Load from 0x0000_0010, memory returns 0xDEAD_BEEF 1 cycle after addr_ok
//     -> data_addr_ok@N, mem_req@N+1, data_data_ok=1 with data_rdata=0xDEAD_BEEF @N+2.
//  2. inst_req and data_req both held, with immediate memory responses
//     -> grants D,D,D,D,I,D,D,D,D,I...; inst_data_ok never produced for a data transaction.
//  3. Store wstrb=4'b0011, addr 0x100, wdata 0x1234_5678; requester changes data_addr during ISSUE
//     -> mem_addr stays 0x100, mem_wstrb stays 0011, mem_wr=1.
//  4. Memory holds mem_addr_ok low for 5 cycles -> mem_req stays high with fields stable.
//     Spurious mem_data_ok during ISSUE -> no data_ok pulse.
//  5. rst asserted in RESP -> IDLE next cycle, mem_req=0, busy=0.
//     A late mem_data_ok after that -> ignored.
//  6. Only inst_req held -> back-to-back fetches every 3 cycles, streak stays 0, fetch grant latches wstrb=0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Shares one sram-like memory port between the instruction fetch requester
// (read-only) and the load/store data requester. At most one transaction is
// outstanding at a time: grant in IDLE, drive the memory in ISSUE, and wait
// for the response in RESP. The data side has priority, and a streak counter
// guarantees that a pending fetch is granted after DATA_STREAK_MAX data grants.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   inst_req/inst_addr            fetch request (held until inst_addr_ok)
//   inst_addr_ok/inst_data_ok     grant pulse / read data valid pulse
//   inst_rdata                    fetch data (0 unless inst_data_ok)
//   data_req/wr/wstrb/addr/wdata  load/store request (held until data_addr_ok)
//   data_addr_ok/data_data_ok     grant pulse / load data or store done pulse
//   data_rdata                    load data (0 unless data_data_ok)
//   mem_req/wr/wstrb/addr/wdata   latched request to memory
//   mem_addr_ok/data_ok/rdata     memory handshake and read data
//   busy                          transaction in flight or a request pending
module sram_port_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned DATA_STREAK_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(DATA_STREAK_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t              r_state;
  logic                r_owner_data;  // 0 = fetch owns the transaction, 1 = data
  logic [CNT_W-1:0]    r_streak;
  logic                r_mem_req;
  logic                r_wr;
  logic [STRB_W-1:0]   r_wstrb;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic w_idle;
  logic w_streak_full;
  logic w_grant_data;
  logic w_grant_inst;
  logic w_resp_done;

  // Grant decision: data wins unless a waiting fetch has been starved long enough.
  assign w_idle        = (r_state == S_IDLE);
  assign w_streak_full = (r_streak == CNT_W'(DATA_STREAK_MAX));
  assign w_grant_data  = w_idle && data_req && !(inst_req && w_streak_full);
  assign w_grant_inst  = w_idle && inst_req && !w_grant_data;
  assign w_resp_done   = (r_state == S_RESP) && mem_data_ok;

  // State, latched request fields and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner_data <= 1'b0;
      r_streak     <= '0;
      r_mem_req    <= 1'b0;
      r_wr         <= 1'b0;
      r_wstrb      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_data) begin
            r_state      <= S_ISSUE;
            r_mem_req    <= 1'b1;
            r_owner_data <= 1'b1;
            r_wr         <= data_wr;
            r_wstrb      <= data_wr ? data_wstrb : '0;
            r_addr       <= data_addr;
            r_wdata      <= data_wdata;
            // Only data grants that bypass a waiting fetch extend the streak.
            if (!inst_req) begin
              r_streak <= '0;
            end else if (!w_streak_full) begin
              r_streak <= r_streak + CNT_W'(1);
            end
          end else if (w_grant_inst) begin
            r_state      <= S_ISSUE;
            r_mem_req    <= 1'b1;
            r_owner_data <= 1'b0;
            r_wr         <= 1'b0;
            r_wstrb      <= '0;
            r_addr       <= inst_addr;
            r_wdata      <= '0;
            r_streak     <= '0;
          end
        end
        S_ISSUE: begin
          if (mem_addr_ok) begin
            r_state   <= S_RESP;
            r_mem_req <= 1'b0;
          end
        end
        S_RESP: begin
          if (mem_data_ok) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Handshake pulses are same-cycle; read data is gated to zero when not valid.
  assign inst_addr_ok = w_grant_inst;
  assign data_addr_ok = w_grant_data;
  assign inst_data_ok = w_resp_done && !r_owner_data;
  assign data_data_ok = w_resp_done && r_owner_data;
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;

  assign mem_req   = r_mem_req;
  assign mem_wr    = r_wr;
  assign mem_wstrb = r_wstrb;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign busy = !w_idle || inst_req || data_req;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        busy;

  // Memory model: auto mode accepts immediately and answers one cycle later;
  // manual mode lets the stimulus drive the handshake directly.
  logic auto_mem;
  logic man_addr_ok;
  logic man_data_ok;
  logic pend;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .DATA_STREAK_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .inst_req(inst_req),
    .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req),
    .data_wr(data_wr),
    .data_wstrb(data_wstrb),
    .data_addr(data_addr),
    .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req),
    .mem_wr(mem_wr),
    .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always_comb begin
    mem_addr_ok = auto_mem ? mem_req : man_addr_ok;
    mem_data_ok = auto_mem ? pend : man_data_ok;
  end

  always @(posedge clk) begin
    if (rst) pend <= 1'b0;
    else     pend <= auto_mem && mem_req && mem_addr_ok;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    string pat;
    int    g;
    int    grant_cyc[3];
    logic  last_d;
    logic  prev_grant;

    rst = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wr = 1'b0;
    data_wstrb = '0; data_addr = '0; data_wdata = '0; mem_rdata = '0;
    auto_mem = 1'b0; man_addr_ok = 1'b0; man_data_ok = 1'b0;

    // Reset state
    step(); step();
    sample();
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    chk("rst_mem_wr", 64'(mem_wr), 64'd0);
    step();
    rst = 1'b0;

    // 1. Load with best-case latency
    auto_mem = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0010; data_wstrb = 4'hF;
    sample();
    chk("t1_data_addr_ok", 64'(data_addr_ok), 64'd1);
    chk("t1_inst_addr_ok", 64'(inst_addr_ok), 64'd0);
    chk("t1_mem_req_n", 64'(mem_req), 64'd0);
    step();
    data_req = 1'b0;
    sample();
    chk("t1_mem_req_n1", 64'(mem_req), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr), 64'h10);
    chk("t1_mem_wr", 64'(mem_wr), 64'd0);
    chk("t1_mem_wstrb_load", 64'(mem_wstrb), 64'd0);
    step();
    sample();
    chk("t1_data_data_ok", 64'(data_data_ok), 64'd1);
    chk("t1_data_rdata", 64'(data_rdata), 64'hDEAD_BEEF);
    chk("t1_inst_data_ok", 64'(inst_data_ok), 64'd0);
    chk("t1_inst_rdata", 64'(inst_rdata), 64'd0);
    chk("t1_mem_req_n2", 64'(mem_req), 64'd0);
    step();
    sample();
    chk("t1_data_ok_clear", 64'(data_data_ok), 64'd0);
    chk("t1_rdata_zero", 64'(data_rdata), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    step();

    // 2. Both requesters held: data streak of 4, then one fetch
    pat = "DDDDIDDDDI";
    g = 0;
    last_d = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_1000;
    data_req = 1'b1; data_addr = 32'h0000_2000; data_wr = 1'b0;
    mem_rdata = 32'h0BAD_F00D;
    for (int cyc = 0; cyc < 200 && g < 10; cyc++) begin
      sample();
      if (data_data_ok) chk("t2_data_owner", 64'(last_d), 64'd1);
      if (inst_data_ok) chk("t2_inst_owner", 64'(last_d), 64'd0);
      if (inst_addr_ok || data_addr_ok) begin
        chk("t2_one_grant", 64'(inst_addr_ok & data_addr_ok), 64'd0);
        chk($sformatf("t2_grant%0d", g), 64'(data_addr_ok ? "D" : "I"), 64'(pat[g]));
        last_d = data_addr_ok;
        g++;
      end
      step();
      if (g == 10) begin
        inst_req = 1'b0;
        data_req = 1'b0;
      end
    end
    chk("t2_grant_count", 64'(g), 64'd10);
    for (int cyc = 0; cyc < 20 && busy; cyc++) begin
      sample();
      if (inst_data_ok) chk("t2_tail_inst_owner", 64'(last_d), 64'd0);
      if (data_data_ok) chk("t2_tail_data_owner", 64'(last_d), 64'd1);
      step();
    end
    sample();
    chk("t2_idle", 64'(busy), 64'd0);
    step();

    // 3. Store fields stay latched while the requester moves on
    auto_mem = 1'b0; man_addr_ok = 1'b0; man_data_ok = 1'b0;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_addr = 32'h0000_0100; data_wdata = 32'h1234_5678;
    sample();
    chk("t3_data_addr_ok", 64'(data_addr_ok), 64'd1);
    step();
    data_req = 1'b0; data_addr = 32'hFFFF_FFF0; data_wstrb = 4'hF; data_wdata = '0; data_wr = 1'b0;
    sample();
    chk("t3_mem_req", 64'(mem_req), 64'd1);
    chk("t3_mem_addr", 64'(mem_addr), 64'h100);
    chk("t3_mem_wstrb", 64'(mem_wstrb), 64'h3);
    chk("t3_mem_wr", 64'(mem_wr), 64'd1);
    chk("t3_mem_wdata", 64'(mem_wdata), 64'h1234_5678);
    step();

    // 4. Memory stalls addr_ok; a spurious data_ok in ISSUE is ignored
    for (int i = 0; i < 5; i++) begin
      man_data_ok = (i == 2);
      sample();
      chk($sformatf("t4_mem_req%0d", i), 64'(mem_req), 64'd1);
      chk($sformatf("t4_mem_addr%0d", i), 64'(mem_addr), 64'h100);
      chk($sformatf("t4_mem_wstrb%0d", i), 64'(mem_wstrb), 64'h3);
      chk($sformatf("t4_no_data_ok%0d", i), 64'(data_data_ok), 64'd0);
      step();
    end
    man_data_ok = 1'b0; man_addr_ok = 1'b1;
    sample();
    chk("t4_mem_req_accept", 64'(mem_req), 64'd1);
    step();
    man_addr_ok = 1'b0;
    sample();
    chk("t4_resp_mem_req", 64'(mem_req), 64'd0);
    chk("t4_resp_wait", 64'(data_data_ok), 64'd0);
    chk("t4_resp_busy", 64'(busy), 64'd1);
    step();
    man_data_ok = 1'b1; mem_rdata = 32'hA5A5_5A5A;
    sample();
    chk("t4_store_done", 64'(data_data_ok), 64'd1);
    chk("t4_store_inst_ok", 64'(inst_data_ok), 64'd0);
    step();
    man_data_ok = 1'b0;
    sample();
    chk("t4_idle", 64'(busy), 64'd0);
    step();

    // 5. Reset while waiting in RESP; late response ignored
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0020;
    sample();
    chk("t5_grant", 64'(data_addr_ok), 64'd1);
    step();
    data_req = 1'b0; man_addr_ok = 1'b1;
    sample();
    chk("t5_issue", 64'(mem_req), 64'd1);
    step();
    man_addr_ok = 1'b0; rst = 1'b1;
    sample();
    chk("t5_resp_busy", 64'(busy), 64'd1);
    chk("t5_resp_no_ok", 64'(data_data_ok), 64'd0);
    step();
    rst = 1'b0; man_data_ok = 1'b1;
    sample();
    chk("t5_after_rst_busy", 64'(busy), 64'd0);
    chk("t5_after_rst_mem_req", 64'(mem_req), 64'd0);
    chk("t5_late_data_ok", 64'(data_data_ok), 64'd0);
    chk("t5_late_inst_ok", 64'(inst_data_ok), 64'd0);
    chk("t5_mem_addr_clr", 64'(mem_addr), 64'd0);
    step();
    man_data_ok = 1'b0;

    // 6. Fetch only: one grant every 3 cycles, strobes forced to 0
    auto_mem = 1'b1;
    data_wr = 1'b1; data_wstrb = 4'hF;
    inst_req = 1'b1; inst_addr = 32'h0000_0400;
    g = 0;
    prev_grant = 1'b0;
    for (int cyc = 0; cyc < 30 && g < 3; cyc++) begin
      sample();
      if (prev_grant) begin
        chk($sformatf("t6_wstrb%0d", g), 64'(mem_wstrb), 64'd0);
        chk($sformatf("t6_wr%0d", g), 64'(mem_wr), 64'd0);
        chk($sformatf("t6_addr%0d", g), 64'(mem_addr), 64'h400);
      end
      prev_grant = inst_addr_ok;
      if (inst_addr_ok) begin
        grant_cyc[g] = cyc;
        g++;
      end
      if (data_addr_ok) chk("t6_no_data_grant", 64'(data_addr_ok), 64'd0);
      step();
      if (g == 3) inst_req = 1'b0;
    end
    chk("t6_grant_count", 64'(g), 64'd3);
    if (g == 3) begin
      chk("t6_gap0", 64'(grant_cyc[1] - grant_cyc[0]), 64'd3);
      chk("t6_gap1", 64'(grant_cyc[2] - grant_cyc[1]), 64'd3);
    end
    for (int cyc = 0; cyc < 20 && busy; cyc++) step();
    sample();
    chk("t6_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
